axi_rd_arbiter: RTL and testbench

Arbitrates the single AXI read address/data channel pair between the instruction-cache refill port and the data-side read port, and sequences one burst at a time from grant through the last returned beat. It sits between the two cache-style read requesters and the AXI master read channels of the SRAM-to-AXI bridge. The write channels are not handled here.

---
 rtl/axi_rd_arbiter_pkg.sv | 24 ++
 rtl/axi_rd_arbiter_rr_arb2.sv | 39 +++
 rtl/axi_rd_arbiter.sv | 143 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared encodings for the AXI read-channel arbiter: FSM states, owners, request types.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam logic [2:0] RD_TYPE_LINE   = 3'b100;
    localparam logic       OWN_INST       = 1'b0;
    localparam logic       OWN_DATA       = 1'b1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Single-beat size; anything that is not a 1/2/4-byte code becomes a 4-byte read.
    function automatic logic [2:0] single_size(input logic [2:0] rd_type);
        unique case (rd_type)
            3'b000:  single_size = 3'd0;
            3'b001:  single_size = 3'd1;
            default: single_size = 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the loser of the previous contested-or-not grant wins ties.
module rr_arb2
    import axi_rd_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req_inst_i,
    input  logic req_data_i,
    output logic gnt_inst_o,
    output logic gnt_data_o,
    output logic winner_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        winner_o = OWN_INST;
        if (req_inst_i && req_data_i) begin
            winner_o = (last_q == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (req_data_i) begin
            winner_o = OWN_DATA;
        end
    end

    assign gnt_inst_o = en_i && req_inst_i && (winner_o == OWN_INST);
    assign gnt_data_o = en_i && req_data_i && (winner_o == OWN_DATA);
    assign last_d     = (gnt_inst_o || gnt_data_o) ? winner_o : last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= OWN_INST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the instruction and data requesters,
// running one burst at a time from grant to the last returned beat.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 4,
    parameter int unsigned ID_INST    = 0,
    parameter int unsigned ID_DATA    = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        i_rd_req,
    input  logic [2:0]  i_rd_type,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,
    input  logic        d_rd_req,
    input  logic [2:0]  d_rd_type,
    input  logic [31:0] d_rd_addr,
    output logic        d_rd_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    arb_state_e  state_q;
    logic        owner_q;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic [2:0]  arsize_q;
    logic        arvalid_q;
    logic        rready_q;

    logic        winner;
    logic        grant;
    logic [2:0]  sel_type;
    logic [31:0] sel_addr;
    logic        in_data;
    logic        unused_r;

    rr_arb2 u_rr_arb2 (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .en_i       (state_q == ARB_IDLE),
        .req_inst_i (i_rd_req),
        .req_data_i (d_rd_req),
        .gnt_inst_o (i_rd_rdy),
        .gnt_data_o (d_rd_rdy),
        .winner_o   (winner)
    );

    assign grant    = i_rd_rdy || d_rd_rdy;
    assign sel_type = (winner == OWN_DATA) ? d_rd_type : i_rd_type;
    assign sel_addr = (winner == OWN_DATA) ? d_rd_addr : i_rd_addr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_INST;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant) begin
                        owner_q   <= winner;
                        arid_q    <= (winner == OWN_DATA) ? 4'(ID_DATA) : 4'(ID_INST);
                        arvalid_q <= 1'b1;
                        state_q   <= ARB_ADDR;
                        if (sel_type == RD_TYPE_LINE) begin
                            araddr_q <= {sel_addr[31:4], 4'h0};
                            arlen_q  <= 8'(LINE_BEATS - 1);
                            arsize_q <= 3'd2;
                        end else begin
                            araddr_q <= sel_addr;
                            arlen_q  <= 8'd0;
                            arsize_q <= single_size(sel_type);
                        end
                    end
                end
                ARB_ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (rvalid && rlast) begin
                        rready_q <= 1'b0;
                        state_q  <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Only one burst is ever outstanding, so the owner flop routes beats; rid is not needed.
    assign in_data     = (state_q == ARB_DATA);
    assign i_ret_valid = in_data && (owner_q == OWN_INST) && rvalid;
    assign d_ret_valid = in_data && (owner_q == OWN_DATA) && rvalid;
    assign i_ret_last  = i_ret_valid && rlast;
    assign d_ret_last  = d_ret_valid && rlast;
    assign i_ret_data  = (in_data && (owner_q == OWN_INST)) ? rdata : '0;
    assign d_ret_data  = (in_data && (owner_q == OWN_DATA)) ? rdata : '0;

    assign arid     = arid_q;
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arsize   = arsize_q;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;
    assign arburst  = AXI_BURST_INCR;
    assign arlock   = 2'b00;
    assign arcache  = 4'h0;
    assign arprot   = 3'b000;
    assign unused_r = ^{rid, rresp};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter with hand-computed expectations.
module tb_axi_rd_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        i_rd_req;
    logic [2:0]  i_rd_type;
    logic [31:0] i_rd_addr;
    logic        i_rd_rdy;
    logic        i_ret_valid;
    logic        i_ret_last;
    logic [31:0] i_ret_data;
    logic        d_rd_req;
    logic [2:0]  d_rd_type;
    logic [31:0] d_rd_addr;
    logic        d_rd_rdy;
    logic        d_ret_valid;
    logic        d_ret_last;
    logic [31:0] d_ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_pass   = 0;

    axi_rd_arbiter #(
        .LINE_BEATS (4),
        .ID_INST    (0),
        .ID_DATA    (1)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_rd_req    (i_rd_req),
        .i_rd_type   (i_rd_type),
        .i_rd_addr   (i_rd_addr),
        .i_rd_rdy    (i_rd_rdy),
        .i_ret_valid (i_ret_valid),
        .i_ret_last  (i_ret_last),
        .i_ret_data  (i_ret_data),
        .d_rd_req    (d_rd_req),
        .d_rd_type   (d_rd_type),
        .d_rd_addr   (d_rd_addr),
        .d_rd_rdy    (d_rd_rdy),
        .d_ret_valid (d_ret_valid),
        .d_ret_last  (d_ret_last),
        .d_ret_data  (d_ret_data),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arlock      (arlock),
        .arcache     (arcache),
        .arprot      (arprot),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_ar(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [3:0] id);
        chk({tag, ".arvalid"}, arvalid, 1);
        chk({tag, ".araddr"},  araddr,  addr);
        chk({tag, ".arlen"},   arlen,   len);
        chk({tag, ".arsize"},  arsize,  size);
        chk({tag, ".arid"},    arid,    id);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".arvalid"},     arvalid,     0);
        chk({tag, ".rready"},      rready,      0);
        chk({tag, ".i_rd_rdy"},    i_rd_rdy,    0);
        chk({tag, ".d_rd_rdy"},    d_rd_rdy,    0);
        chk({tag, ".i_ret_valid"}, i_ret_valid, 0);
        chk({tag, ".d_ret_valid"}, d_ret_valid, 0);
        chk({tag, ".i_ret_last"},  i_ret_last,  0);
        chk({tag, ".d_ret_last"},  d_ret_last,  0);
        chk({tag, ".i_ret_data"},  i_ret_data,  0);
        chk({tag, ".d_ret_data"},  d_ret_data,  0);
        chk({tag, ".araddr"},      araddr,      0);
        chk({tag, ".arid"},        arid,        0);
        chk({tag, ".arlen"},       arlen,       0);
        chk({tag, ".arsize"},      arsize,      0);
    endtask

    // Address handshake: arready for one cycle, then rready must be up.
    task automatic ar_accept(input string tag);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk({tag, ".arvalid_drop"}, arvalid, 0);
        chk({tag, ".rready"},       rready,  1);
    endtask

    initial begin
        logic [31:0] saved_addr;
        logic        pat [7];
        int          beat;
        int          pulses;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        aresetn   = 1'b0;
        i_rd_req  = 1'b0;
        i_rd_type = 3'b000;
        i_rd_addr = '0;
        d_rd_req  = 1'b0;
        d_rd_type = 3'b000;
        d_rd_addr = '0;
        arready   = 1'b0;
        rid       = 4'h0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rvalid    = 1'b0;

        #2;
        chk_reset_outs("rst");
        chk("rst.arburst", arburst, 32'h1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Instruction refill alone
        i_rd_req  = 1'b1;
        i_rd_type = 3'b100;
        i_rd_addr = 32'h1C00_0014;
        #1;
        chk("ifill.i_rdy", i_rd_rdy, 1);
        chk("ifill.d_rdy", d_rd_rdy, 0);
        step();
        i_rd_req = 1'b0;
        chk_ar("ifill", 32'h1C00_0010, 8'd3, 3'd2, 4'd0);
        chk("ifill.rdy_in_addr", i_rd_rdy, 0);
        ar_accept("ifill");
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1;
            rdata  = 32'hA000_0000 + 32'(k);
            rlast  = (k == 3);
            #1;
            chk("ifill.i_ret_valid", i_ret_valid, 1);
            chk("ifill.i_ret_data",  i_ret_data,  32'hA000_0000 + 32'(k));
            chk("ifill.i_ret_last",  i_ret_last,  (k == 3) ? 32'd1 : 32'd0);
            chk("ifill.d_ret_valid", d_ret_valid, 0);
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk("ifill.rready_end", rready, 0);

        // Data single byte
        d_rd_req  = 1'b1;
        d_rd_type = 3'b000;
        d_rd_addr = 32'h8000_0003;
        #1;
        chk("dbyte.d_rdy", d_rd_rdy, 1);
        chk("dbyte.i_rdy", i_rd_rdy, 0);
        step();
        d_rd_req = 1'b0;
        chk_ar("dbyte", 32'h8000_0003, 8'd0, 3'd0, 4'd1);
        ar_accept("dbyte");
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 32'h0000_00EE;
        #1;
        chk("dbyte.d_ret_valid", d_ret_valid, 1);
        chk("dbyte.d_ret_last",  d_ret_last,  1);
        chk("dbyte.d_ret_data",  d_ret_data,  32'h0000_00EE);
        chk("dbyte.i_ret_valid", i_ret_valid, 0);
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;

        // Fresh reset, then a tie: DATA must win first
        aresetn = 1'b0;
        #1;
        aresetn = 1'b1;
        step();
        i_rd_req  = 1'b1;
        i_rd_type = 3'b100;
        i_rd_addr = 32'h0000_0020;
        d_rd_req  = 1'b1;
        d_rd_type = 3'b010;
        d_rd_addr = 32'h0000_1236;
        #1;
        chk("tie1.d_rdy", d_rd_rdy, 1);
        chk("tie1.i_rdy", i_rd_rdy, 0);
        step();
        d_rd_req = 1'b0;

        // arready held low for 5 cycles; INST still requesting but must not see rdy
        saved_addr = araddr;
        for (int k = 0; k < 5; k++) begin
            chk_ar("stall", 32'h0000_1236, 8'd0, 3'd2, 4'd1);
            chk("stall.araddr_stable", araddr, saved_addr);
            chk("stall.i_rdy", i_rd_rdy, 0);
            chk("stall.d_rdy", d_rd_rdy, 0);
            step();
        end
        ar_accept("tie1");
        chk("tie1.i_rdy_data", i_rd_rdy, 0);
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 32'h1234_5678;
        #1;
        chk("tie1.d_ret_valid", d_ret_valid, 1);
        chk("tie1.d_ret_data",  d_ret_data,  32'h1234_5678);
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;

        // IDLE right after rlast: tie again, last owner DATA, so INST wins
        d_rd_req  = 1'b1;
        d_rd_type = 3'b001;
        d_rd_addr = 32'h0000_3002;
        #1;
        chk("tie2.i_rdy", i_rd_rdy, 1);
        chk("tie2.d_rdy", d_rd_rdy, 0);
        step();
        i_rd_req = 1'b0;
        chk_ar("tie2", 32'h0000_0020, 8'd3, 3'd2, 4'd0);
        ar_accept("tie2");

        // rvalid gaps mid-burst
        beat   = 0;
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            rvalid = pat[k];
            rdata  = 32'hB000_0000 + 32'(beat);
            rlast  = pat[k] && (beat == 3);
            #1;
            if (i_ret_valid) pulses++;
            if (pat[k]) begin
                chk("gap.i_ret_data", i_ret_data, 32'hB000_0000 + 32'(beat));
                chk("gap.i_ret_last", i_ret_last, (beat == 3) ? 32'd1 : 32'd0);
                beat++;
            end else begin
                chk("gap.i_ret_valid_idle", i_ret_valid, 0);
                chk("gap.rready_held",      rready,      1);
            end
            chk("gap.d_ret_valid", d_ret_valid, 0);
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk("gap.pulses", pulses, 4);
        chk("gap.rready_end", rready, 0);

        // Repeated tie after INST owned last: DATA again
        i_rd_req = 1'b1;
        #1;
        chk("tie3.d_rdy", d_rd_rdy, 1);
        chk("tie3.i_rdy", i_rd_rdy, 0);
        step();
        d_rd_req = 1'b0;
        chk_ar("tie3", 32'h0000_3002, 8'd0, 3'd1, 4'd1);
        ar_accept("tie3");
        rvalid = 1'b1;
        rlast  = 1'b1;
        #1;
        chk("tie3.d_ret_last", d_ret_last, 1);
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;

        // INST refill pending; reset lands during beat 2
        #1;
        chk("rstmid.i_rdy", i_rd_rdy, 1);
        step();
        i_rd_req = 1'b0;
        ar_accept("rstmid");
        rvalid = 1'b1;
        rdata  = 32'hC000_0000;
        #1;
        chk("rstmid.beat1", i_ret_valid, 1);
        step();
        rdata = 32'hC000_0001;
        #1;
        aresetn = 1'b0;
        #1;
        chk_reset_outs("rstmid");
        rvalid = 1'b0;
        step();
        aresetn = 1'b1;
        step();

        // Undefined type after reset: 4-byte single read
        d_rd_req  = 1'b1;
        d_rd_type = 3'b111;
        d_rd_addr = 32'h0000_0044;
        #1;
        chk("post.d_rdy", d_rd_rdy, 1);
        step();
        d_rd_req = 1'b0;
        chk_ar("post", 32'h0000_0044, 8'd0, 3'd2, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
